// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hold/flush sequencer.
package pipe_hold_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_DIV_WAIT = 2'd3
   } state_t;

   localparam int INST_ADDR_WIDTH = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = '0;

endpackage

// File: rtl/pipe_hold_ctrl_bus_wdt.sv
// Bus wait-state watchdog: counts stalled MEM_WAIT cycles, saturating at LIMIT-1.
// expire is combinational and only asserts while enable is high at the last count.
module pipe_hold_ctrl_bus_wdt #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = $clog2(LIMIT + 1);
   localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

   logic [TW-1:0] timer;

   // start wins over clear so a fresh stall always begins at 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (start) begin
         timer <= TW'(1);
      end else if (clear) begin
         timer <= '0;
      end else if (enable && (timer != LAST)) begin
         timer <= timer + TW'(1);
      end
   end

   assign expire = enable && (timer == LAST);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Hazard/stall sequencer driving PC, IF/ID and ID/EX hold/flush controls.
// Outputs decode registered state with the current requests for same-cycle response.
module pipe_hold_ctrl
   import pipe_hold_ctrl_pkg::*;
#(
   parameter int ADDR_W       = INST_ADDR_WIDTH,
   parameter int FLUSH_CYCLES = 2,
   parameter int BUS_TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_req_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              load_use_i,
   input  logic              div_busy_i,
   input  logic              mem_req_i,
   input  logic              mem_ack_i,
   output logic              hold_pc_o,
   output logic              hold_if_id_o,
   output logic              hold_id_ex_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              jump_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              bus_err_o,
   output logic [1:0]        state_o
);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       take_jump, wdt_start, wdt_clear, wdt_en, wdt_expire;
   logic       hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, bus_err;
   logic       mem_stall;

   assign mem_stall = mem_req_i && !mem_ack_i;

   pipe_hold_ctrl_bus_wdt #(.LIMIT(BUS_TIMEOUT)) u_bus_wdt (
      .clk    (clk),
      .rst    (rst),
      .start  (wdt_start),
      .clear  (wdt_clear),
      .enable (wdt_en),
      .expire (wdt_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      take_jump   = 1'b0;
      wdt_start   = 1'b0;
      wdt_clear   = 1'b0;
      wdt_en      = 1'b0;
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      bus_err     = 1'b0;
      case (state)
         ST_RUN: begin
            if (jump_req_i) begin
               take_jump = 1'b1;
            end else if (mem_stall) begin
               {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
               wdt_start = 1'b1;
               state_nxt = ST_MEM_WAIT;
            end else if (div_busy_i) begin
               {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
               state_nxt = ST_DIV_WAIT;
            end else if (load_use_i) begin
               hold_pc     = 1'b1;
               hold_if_id  = 1'b1;
               flush_id_ex = 1'b1;
            end
         end
         ST_FLUSH: begin
            if (jump_req_i) begin
               take_jump = 1'b1;
            end else if (mem_stall) begin
               {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
            end else begin
               flush_if_id = 1'b1;
               cnt_nxt     = (cnt > 4'd0) ? cnt - 4'd1 : 4'd0;
               if (cnt <= 4'd1) state_nxt = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            // ack takes precedence over an expiring watchdog
            wdt_en = !mem_ack_i;
            if (mem_ack_i) begin
               wdt_clear = 1'b1;
               state_nxt = ST_RUN;
            end else if (wdt_expire) begin
               bus_err     = 1'b1;
               flush_id_ex = 1'b1;
               hold_pc     = 1'b1;
               hold_if_id  = 1'b1;
               wdt_clear   = 1'b1;
               state_nxt   = ST_RUN;
            end else begin
               {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
            end
         end
         ST_DIV_WAIT: begin
            if (div_busy_i) begin
               {hold_pc, hold_if_id, hold_id_ex} = 3'b111;
            end else begin
               state_nxt = ST_RUN;
               take_jump = jump_req_i;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
      if (take_jump) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
         cnt_nxt     = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
         state_nxt   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end
   end

   // reset masks every output independently of the registered state
   assign hold_pc_o     = rst && hold_pc;
   assign hold_if_id_o  = rst && hold_if_id;
   assign hold_id_ex_o  = rst && hold_id_ex;
   assign flush_if_id_o = rst && flush_if_id;
   assign flush_id_ex_o = rst && flush_id_ex;
   assign jump_o        = rst && take_jump;
   assign jump_addr_o   = (rst && take_jump) ? jump_addr_i : '0;
   assign bus_err_o     = rst && bus_err;
   assign state_o       = rst ? state : ST_RUN;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Randomized bench for pipe_hold_ctrl with a cycle-level behavioural reference.
module tb_pipe_hold_ctrl;

   localparam int FC = 2;
   localparam int BT = 16;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          jump_req = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          load_use = 1'b0;
   logic          div_busy = 1'b0;
   logic          mem_req = 1'b0;
   logic          mem_ack = 1'b0;
   logic          hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o;
   logic          jump_o, bus_err_o;
   logic [AW-1:0] jump_addr_o;
   logic [1:0]    state_o;

   int checks = 0;
   int failures = 0;

   // reference: remaining IF/ID flush cycles, stalled-bus cycle count, divider wait flag
   int m_flush_left = 0;
   int m_wait = 0;
   bit m_div = 1'b0;
   logic [8:0]    e_vec;
   logic [AW-1:0] e_addr;

   pipe_hold_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .BUS_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst),
      .jump_req_i(jump_req), .jump_addr_i(jump_addr), .load_use_i(load_use),
      .div_busy_i(div_busy), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
      .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
      .jump_o(jump_o), .jump_addr_o(jump_addr_o), .bus_err_o(bus_err_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] act_vec();
      return {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
              jump_o, bus_err_o, state_o};
   endfunction

   task automatic model_eval();
      bit hp = 0, hi = 0, he = 0, fi = 0, fe = 0, jo = 0, be = 0;
      logic [1:0] st;
      if (m_wait > 0) begin
         st = 2'd2;
         if (mem_ack) m_wait = 0;
         else if (m_wait == BT - 1) begin
            be = 1; fe = 1; hp = 1; hi = 1; m_wait = 0;
         end else begin
            hp = 1; hi = 1; he = 1; m_wait++;
         end
      end else if (m_div) begin
         st = 2'd3;
         if (div_busy) begin
            hp = 1; hi = 1; he = 1;
         end else begin
            m_div = 0;
            jo = jump_req;
         end
      end else if (m_flush_left > 0) begin
         st = 2'd1;
         if (jump_req) jo = 1;
         else if (mem_req && !mem_ack) begin
            hp = 1; hi = 1; he = 1;
         end else begin
            fi = 1; m_flush_left--;
         end
      end else begin
         st = 2'd0;
         if (jump_req) jo = 1;
         else if (mem_req && !mem_ack) begin
            hp = 1; hi = 1; he = 1; m_wait = 1;
         end else if (div_busy) begin
            hp = 1; hi = 1; he = 1; m_div = 1;
         end else if (load_use) begin
            hp = 1; hi = 1; fe = 1;
         end
      end
      if (jo) begin
         fi = 1; fe = 1; m_flush_left = FC - 1;
      end
      e_vec  = {hp, hi, he, fi, fe, jo, be, st};
      e_addr = jo ? jump_addr : '0;
   endtask

   task automatic step(input bit j, input logic [AW-1:0] a, input bit lu, input bit dv,
                       input bit mr, input bit ak);
      @(posedge clk);
      #1;
      jump_req = j; jump_addr = a; load_use = lu; div_busy = dv; mem_req = mr; mem_ack = ak;
      #4;
      model_eval();
      chk("outputs", act_vec(), e_vec);
      chk("jump_addr", jump_addr_o, e_addr);
      chk("hold_and_flush", (hold_if_id_o & flush_if_id_o) | (hold_id_ex_o & flush_id_ex_o), 0);
   endtask

   task automatic idle();
      step(0, '0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_flush_left = 0; m_wait = 0; m_div = 0;
   endtask

   initial begin
      // reset with active requests: every output must stay low
      jump_req = 1; jump_addr = 32'hDEAD_BEEF; load_use = 1; mem_req = 1;
      #23;
      chk("reset_outputs", {act_vec(), jump_addr_o}, 0);
      jump_req = 0; jump_addr = '0; load_use = 0; mem_req = 0;
      #2 rst = 1'b1;

      // jump with two flush cycles
      step(1, 32'h0000_0100, 0, 0, 0, 0);
      chk("jump_c0_jump", jump_o, 1);
      chk("jump_c0_addr", jump_addr_o, 32'h100);
      chk("jump_c0_flush", {flush_if_id_o, flush_id_ex_o}, 2'b11);
      idle();
      chk("jump_c1_flush", {flush_if_id_o, flush_id_ex_o, state_o}, {2'b10, 2'd1});
      idle();
      chk("jump_c2_state", {flush_if_id_o, state_o}, 0);

      // load-use bubble
      step(0, '0, 1, 0, 0, 0);
      chk("lu_outputs", {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_id_ex_o, state_o}, 6'b110100);
      idle();
      chk("lu_after", {hold_pc_o, hold_if_id_o, flush_id_ex_o}, 0);

      // bus ack after three stalled cycles
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 0, 0, 1, 0);
         chk("mem_hold", {hold_pc_o, hold_if_id_o, hold_id_ex_o}, 3'b111);
      end
      step(0, '0, 0, 0, 1, 1);
      chk("mem_ack_cycle", {hold_pc_o, hold_if_id_o, hold_id_ex_o, state_o}, {3'b000, 2'd2});
      idle();
      chk("mem_after", state_o, 0);

      // bus timeout
      for (int i = 0; i < BT - 1; i++) begin
         step(0, '0, 0, 0, 1, 0);
         chk("tmo_hold", {hold_id_ex_o, bus_err_o}, 2'b10);
      end
      step(0, '0, 0, 0, 1, 0);
      chk("tmo_err", {bus_err_o, flush_id_ex_o, hold_pc_o, hold_if_id_o, hold_id_ex_o}, 5'b11110);
      idle();
      chk("tmo_after", {bus_err_o, state_o}, 0);

      // divide stall with a pending jump
      step(0, '0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h0000_2000, 0, 1, 0, 0);
         chk("div_no_jump", {jump_o, hold_id_ex_o}, 2'b01);
      end
      step(1, 32'h0000_2000, 0, 0, 0, 0);
      chk("div_exit_jump", {jump_o, jump_addr_o}, {1'b1, 32'h0000_2000});
      idle();
      chk("div_flush_seq", {flush_if_id_o, state_o}, {1'b1, 2'd1});
      idle();

      // asynchronous reset in the middle of a bus stall
      for (int i = 0; i < 4; i++) step(0, '0, 0, 0, 1, 0);
      chk("pre_rst_state", state_o, 2);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_outputs", {act_vec(), jump_addr_o}, 0);
      chk("rst_mid_timer", dut.u_bus_wdt.timer, 0);
      chk("rst_mid_state", dut.state, 0);
      model_reset();
      mem_req = 0;
      #1 rst = 1'b1;
      idle();

      // randomized traffic with phases of slow and fast bus acks
      for (int i = 0; i < 3000; i++) begin
         automatic int ack_div = ((i / 500) % 2 == 0) ? 2 : 20;
         step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
              $urandom_range(0, ack_div - 1) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central hazard/stall sequencer for the 32-bit in-order core.
- Drives the hold and flush inputs of the PC register, the IF/ID stage register and the ID/EX stage register.
- Arbitrates between jump redirects, load-use bubbles, multi-cycle divide stalls and bus wait states, with a bus-timeout watchdog.
- Outputs are combinational from registered state plus current requests, giving zero-cycle hazard response.

Parameters:
- ADDR_W, 32, width of jump_addr_i/jump_addr_o; equals `INST_ADDR_WIDTH.
- FLUSH_CYCLES, 2, number of cycles IF/ID is flushed after a jump; legal range 1..15.
- BUS_TIMEOUT, 16, number of MEM_WAIT cycles without ack before bus_err_o; legal range 2..255.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- jump_req_i  in  1  EX-stage redirect request.
- jump_addr_i  in  ADDR_W  redirect target.
- load_use_i  in  1  ID-stage load-use hazard detected.
- div_busy_i  in  1  multi-cycle divider busy in EX.
- mem_req_i  in  1  MEM stage has an outstanding bus access.
- mem_ack_i  in  1  bus acknowledges the access this cycle.
- hold_pc_o  out  1  PC keeps its value.
- hold_if_id_o  out  1  IF/ID keeps its value.
- hold_id_ex_o  out  1  ID/EX keeps its value.
- flush_if_id_o  out  1  IF/ID loads `NOP / `INI_INST_ADDR at the next edge.
- flush_id_ex_o  out  1  ID/EX loads a bubble at the next edge.
- jump_o  out  1  PC redirect strobe.
- jump_addr_o  out  ADDR_W  PC redirect target.
- bus_err_o  out  1  one-cycle pulse on bus timeout.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, flush counter=0, timer=0. While rst=0, every output is forced to 0.
- Hold has priority over flush within the same stage register; the controller never asserts both on one stage.
- States: RUN=0, FLUSH=1, MEM_WAIT=2, DIV_WAIT=3.
- RUN priority order: jump > mem stall > div stall > load-use.
  - jump_req_i:
    - jump_o=1 and jump_addr_o=jump_addr_i in the same cycle.
    - flush_if_id_o=1 and flush_id_ex_o=1; no holds.
    - If FLUSH_CYCLES>1: counter=FLUSH_CYCLES-1, next state FLUSH. Otherwise stay in RUN.
  - mem_req_i && !mem_ack_i: hold_pc/if_id/id_ex=1 this cycle; timer=1; next state MEM_WAIT.
  - mem_req_i && mem_ack_i: no stall.
  - div_busy_i: all three holds=1; next state DIV_WAIT.
  - load_use_i alone: hold_pc=1, hold_if_id=1, flush_id_ex=1 for exactly that cycle; no state change.
- FLUSH:
  - flush_if_id_o=1 each cycle; counter decrements; state returns to RUN when the counter reaches 0.
  - A new jump_req_i restarts the sequence: outputs as in RUN, counter reloaded.
  - mem_req_i && !mem_ack_i: all holds=1, flush_if_id_o=0, counter frozen.
  - div_busy_i and load_use_i are ignored (only bubbles are in flight).
- MEM_WAIT:
  - All holds=1 while !mem_ack_i; timer increments each cycle.
  - Ack cycle: holds=0; next state RUN; timer cleared.
  - Timeout: when timer==BUS_TIMEOUT-1 and !mem_ack_i:
    - bus_err_o=1 and flush_id_ex_o=1 for one cycle.
    - Holds for that cycle: hold_pc=1, hold_if_id=1.
    - Next state RUN.
  - jump_req_i is ignored; EX is held, so the request persists and is taken in RUN.
  - Ack and timeout in the same cycle: the ack wins.
- DIV_WAIT:
  - All holds=1 while div_busy_i=1.
  - First cycle with div_busy_i=0: holds=0, next state RUN, and a jump_req_i present in that cycle is serviced exactly as in RUN.
- Timer width is ceil(log2(BUS_TIMEOUT+1)) and never wraps; it saturates at the timeout point. Counter width is 4 bits.
- Reset asserted mid-stall returns to RUN immediately, with all holds and flushes deasserted.

Decomposition:
- Shared package/defines: state encodings (ST_RUN, ST_FLUSH, ST_MEM_WAIT, ST_DIV_WAIT), `NOP, `INI_INST_ADDR, `INST_ADDR_WIDTH.
- One natural sub-module: bus_wdt, the timeout counter. Inputs: start/clear/enable. Output: expire pulse.
- The FSM and the output decode stay in pipe_hold_ctrl.

Test Plan:
- Jump 0x0000_0100 in RUN, FLUSH_CYCLES=2 -> jump_o=1, jump_addr_o=0x100 and both flushes in cycle 0; flush_if_id only in cycle 1; state RUN in cycle 2.
- load_use_i pulse for 1 cycle -> hold_pc=hold_if_id=flush_id_ex=1 for that cycle only; state_o stays 0.
- mem_req_i=1, ack after 3 cycles -> holds high for 3 cycles, low in the ack cycle, state 2 then 0.
- mem_req_i=1, no ack, BUS_TIMEOUT=16 -> holds for 15 cycles, then bus_err_o plus flush_id_ex for 1 cycle, state back to 0.
- div_busy_i high for 5 cycles with jump_req_i asserted throughout -> jump_o stays 0 until div_busy_i falls, then jump_o=1 and the flush sequence starts.
- Reset asserted in MEM_WAIT mid-stall -> all outputs 0 asynchronously; after release state_o=0 and timer=0.
